// File: rtl/seq_multiply_param.sv
// Iterative shift-add multiplier: one partial product per clock, signed/unsigned per
// operation, optional early exit once the remaining multiplier bits are all zero.
module seq_multiply_param #(
    parameter int unsigned WIDTH      = 16,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic [2*WIDTH-1:0]   product,
    output logic                 ready,
    output logic                 busy,
    output logic                 done
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   mplr;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               neg;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   mplr_next;
    logic [2*WIDTH-1:0] acc_next;
    logic               last;
    logic               accept;

    // Magnitudes are taken as unsigned WIDTH bits, so |-2^(WIDTH-1)| fits without overflow.
    always_comb begin
        mag_a     = (is_signed && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
        mag_b     = (is_signed && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
        mplr_next = mplr >> 1;
        acc_next  = mplr[0] ? (acc + mcand) : acc;
        last      = (cnt == CW'(WIDTH - 1)) || (EARLY_EXIT && (mplr_next == '0));
        accept    = start && ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            product <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            mplr    <= '0;
            mcand   <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        mplr  <= mag_a;
                        mcand <= {{WIDTH{1'b0}}, mag_b};
                        acc   <= '0;
                        cnt   <= '0;
                        neg   <= is_signed && (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
                        state <= CALC;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    mplr  <= mplr_next;
                    mcand <= mcand << 1;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        product <= neg ? -acc_next : acc_next;
                        state   <= DONE;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
